// File: rtl/io_ctrl_if.sv
// Load/store bus between the CPU datapath and io_ctrl.
// The master drives the effective address and strobes; io_ctrl answers with io_hit and rdata.
interface io_ctrl_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic             io_hit;
  logic [DBITS-1:0] rdata;

  modport master (output addr, wdata, we, re, input io_hit, rdata);
  modport slave  (input addr, wdata, we, re, output io_hit, rdata);
endinterface

// File: rtl/io_ctrl.sv
// Memory-mapped I/O: HEX/LEDR/LEDG output registers plus synchronized KEY/SW inputs with sticky key-press flags.
// Define IO_DEBOUNCE_EN to add a per-bit stable-count filter on KEY and SW.
module io_ctrl #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_LEDG       = 32'hF0000008,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  io_ctrl_if.slave    bus,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [15:0] HEX,
  output logic [9:0]  LEDR,
  output logic [7:0]  LEDG
);

  // Inputs are handled as one 14-bit vector: KEY in [3:0], SW in [13:4].
  localparam int             NIN    = 14;
  localparam logic [NIN-1:0] IN_RST = {10'b0, 4'hF};

  logic [NIN-1:0]   rawIn;
  logic [NIN-1:0]   sync1;
  logic [NIN-1:0]   sync2;
  logic [NIN-1:0]   filt;
  logic [3:0]       keyF;
  logic [3:0]       keyFd;
  logic [3:0]       press;
  logic [3:0]       pressSet;
  logic [3:0]       pressClr;
  logic [9:0]       swF;
  logic             hit;
  logic             wrHex;
  logic             wrLedr;
  logic             wrLedg;
  logic             wrKey;
  logic [DBITS-1:0] rdataMux;
  logic             unusedWdata;

  assign rawIn       = {SW, KEY};
  assign hit         = (bus.addr[31:8] == 24'hF00000);
  assign wrHex       = bus.we && hit && (bus.addr == ADDR_HEX);
  assign wrLedr      = bus.we && hit && (bus.addr == ADDR_LEDR);
  assign wrLedg      = bus.we && hit && (bus.addr == ADDR_LEDG);
  assign wrKey       = bus.we && hit && (bus.addr == ADDR_KEY);
  assign unusedWdata = ^bus.wdata[DBITS-1:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IN_RST;
      sync2 <= IN_RST;
    end else begin
      sync1 <= rawIn;
      sync2 <= sync1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [NIN];

  // A bit only follows its synchronizer after staying different for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= IN_RST;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  localparam int unusedDebounce = DEBOUNCE_CYCLES;

  assign filt = sync2;
`endif

  assign keyF = filt[3:0];
  assign swF  = filt[13:4];

  // A press sets on a filtered 1->0 edge; set beats a same-cycle W1C.
  assign pressSet = keyFd & ~keyF;
  assign pressClr = wrKey ? bus.wdata[7:4] : 4'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keyFd <= 4'hF;
      press <= 4'b0;
    end else begin
      keyFd <= keyF;
      press <= (press & ~pressClr) | pressSet;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      HEX  <= '0;
      LEDR <= '0;
      LEDG <= '0;
    end else begin
      if (wrHex)  HEX  <= bus.wdata[15:0];
      if (wrLedr) LEDR <= bus.wdata[9:0];
      if (wrLedg) LEDG <= bus.wdata[7:0];
    end
  end

  // Reads see the registers before any same-cycle write lands.
  always_comb begin
    rdataMux = '0;
    if (bus.re && hit) begin
      case (bus.addr)
        ADDR_HEX:  rdataMux = DBITS'(HEX);
        ADDR_LEDR: rdataMux = DBITS'(LEDR);
        ADDR_LEDG: rdataMux = DBITS'(LEDG);
        ADDR_KEY:  rdataMux = DBITS'({press, ~keyF});
        ADDR_SW:   rdataMux = DBITS'(swF);
        default:   rdataMux = '0;
      endcase
    end
  end

  assign bus.rdata  = rdataMux;
  assign bus.io_hit = hit;

endmodule

// File: tb/tb_io_ctrl.sv
// Bench for io_ctrl: constant vector table, hand sequences for key timing and reset, and a random run
// compared against a cycle-level reference model of the register map and filtered inputs.
`timescale 1ns/1ps
module tb_io_ctrl;

  localparam int          DBITS  = 32;
  localparam int          DEB    = 16;
  localparam logic [31:0] A_HEX  = 32'hF0000000;
  localparam logic [31:0] A_LEDR = 32'hF0000004;
  localparam logic [31:0] A_LEDG = 32'hF0000008;
  localparam logic [31:0] A_KEY  = 32'hF0000010;
  localparam logic [31:0] A_SW   = 32'hF0000014;
  localparam logic [13:0] IN_RST = {10'b0, 4'hF};
`ifdef IO_DEBOUNCE_EN
  localparam int FILT_LAT = DEB;
`else
  localparam int FILT_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [15:0] HEX;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  int          checks = 0;
  int          failures = 0;

  io_ctrl_if #(.DBITS(DBITS)) bus();

  io_ctrl #(.DBITS(DBITS), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .KEY(KEY), .SW(SW), .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG)
  );

  always #5 clk = ~clk;

  // Reference model: register contents and the filtered view of the inputs.
  logic [15:0] mHex;
  logic [9:0]  mLedr;
  logic [7:0]  mLedg;
  logic [3:0]  mPress;
  logic [3:0]  mKeyPrev;
  logic [13:0] mFilt;
  logic [13:0] mSeen[$];
  int          mRun[14];

  task automatic modelReset();
    mHex = '0; mLedr = '0; mLedg = '0; mPress = '0; mKeyPrev = 4'hF;
    mFilt = IN_RST;
    mSeen = '{IN_RST, IN_RST};
    for (int i = 0; i < 14; i++) mRun[i] = 0;
  endtask

  task automatic modelEdge();
    logic [3:0]  clr;
    logic [3:0]  keyNow;
    logic [13:0] older;
    clr = '0;
    keyNow = mFilt[3:0];
    older = mSeen[1];
    if (bus.we && bus.addr[31:8] == 24'hF00000) begin
      case (bus.addr)
        A_HEX:   mHex = bus.wdata[15:0];
        A_LEDR:  mLedr = bus.wdata[9:0];
        A_LEDG:  mLedg = bus.wdata[7:0];
        A_KEY:   clr = bus.wdata[7:4];
        default: ;
      endcase
    end
    mPress = (mPress & ~clr) | (mKeyPrev & ~keyNow);
    mKeyPrev = keyNow;
    void'(mSeen.pop_back());
    mSeen.push_front({SW, KEY});
`ifdef IO_DEBOUNCE_EN
    for (int i = 0; i < 14; i++) begin
      if (older[i] == mFilt[i]) mRun[i] = 0;
      else begin
        mRun[i]++;
        if (mRun[i] == DEB) begin
          mFilt[i] = older[i];
          mRun[i] = 0;
        end
      end
    end
`else
    mFilt = mSeen[1];
`endif
  endtask

  function automatic logic [31:0] expRead(logic [31:0] a, logic r);
    if (!(r && a[31:8] == 24'hF00000)) return '0;
    case (a)
      A_HEX:   return {16'b0, mHex};
      A_LEDR:  return {22'b0, mLedr};
      A_LEDG:  return {24'b0, mLedg};
      A_KEY:   return {24'b0, mPress, ~mFilt[3:0]};
      A_SW:    return {22'b0, mFilt[13:4]};
      default: return '0;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkRegs(string tag);
    checkOutput({tag, " HEX"}, HEX, mHex);
    checkOutput({tag, " LEDR"}, LEDR, mLedr);
    checkOutput({tag, " LEDG"}, LEDG, mLedg);
  endtask

  task automatic applyStimulus(logic [31:0] a, logic [31:0] d, logic w, logic r);
    bus.addr = a; bus.wdata = d; bus.we = w; bus.re = r;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) modelEdge();
    #1;
  endtask

  task automatic idle(int n);
    applyStimulus('0, '0, 1'b0, 1'b0);
    repeat (n) tick();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        hit;
    logic [31:0] rd;
    logic [15:0] hex;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addrs[8];
    int hold;

    vecs[0]  = '{A_HEX,        32'h00001234, 1'b1, 1'b0, 1'b1, 32'h0,    16'h1234, 10'h0,   8'h00};
    vecs[1]  = '{A_HEX,        32'h0,        1'b0, 1'b1, 1'b1, 32'h1234, 16'h1234, 10'h0,   8'h00};
    vecs[2]  = '{A_LEDG,       32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h0,    16'h1234, 10'h0,   8'hFF};
    vecs[3]  = '{A_LEDG,       32'h0,        1'b0, 1'b1, 1'b1, 32'hFF,   16'h1234, 10'h0,   8'hFF};
    vecs[4]  = '{A_LEDR,       32'h0000ABCD, 1'b1, 1'b1, 1'b1, 32'h0,    16'h1234, 10'h3CD, 8'hFF};
    vecs[5]  = '{A_SW,         32'h0,        1'b1, 1'b1, 1'b1, 32'h2A5,  16'h1234, 10'h3CD, 8'hFF};
    vecs[6]  = '{A_SW,         32'h0,        1'b0, 1'b1, 1'b1, 32'h2A5,  16'h1234, 10'h3CD, 8'hFF};
    vecs[7]  = '{32'hF0000020, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h0,    16'h1234, 10'h3CD, 8'hFF};
    vecs[8]  = '{32'hF0000020, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,    16'h1234, 10'h3CD, 8'hFF};
    vecs[9]  = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h0,    16'h1234, 10'h3CD, 8'hFF};
    vecs[10] = '{A_HEX,        32'h0,        1'b0, 1'b1, 1'b1, 32'h1234, 16'h1234, 10'h3CD, 8'hFF};
    vecs[11] = '{A_LEDR,       32'h0,        1'b0, 1'b1, 1'b1, 32'h3CD,  16'h1234, 10'h3CD, 8'hFF};
    vecs[12] = '{A_HEX,        32'h0000FFFF, 1'b0, 1'b0, 1'b1, 32'h0,    16'h1234, 10'h3CD, 8'hFF};

    reset_n = 1'b0;
    KEY = 4'hF;
    SW = 10'h2A5;
    applyStimulus(A_KEY, '0, 1'b0, 1'b1);
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset HEX", HEX, 32'h0);
    checkOutput("reset LEDR", LEDR, 32'h0);
    checkOutput("reset LEDG", LEDG, 32'h0);
    checkOutput("reset KEY read", bus.rdata, 32'h0);
    checkOutput("reset io_hit", bus.io_hit, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    idle(40);

    applyStimulus(A_KEY, '0, 1'b0, 1'b1);
    #1;
    checkOutput("no spurious press", bus.rdata, 32'h0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
      #1;
      checkOutput($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].rd);
      checkOutput($sformatf("vec%0d io_hit", i), bus.io_hit, {31'b0, vecs[i].hit});
      tick();
      checkOutput($sformatf("vec%0d HEX", i), HEX, vecs[i].hex);
      checkOutput($sformatf("vec%0d LEDR", i), LEDR, vecs[i].ledr);
      checkOutput($sformatf("vec%0d LEDG", i), LEDG, vecs[i].ledg);
    end

    // Key 0 held, then its press flag cleared while the key stays down.
    KEY = 4'b1110;
    applyStimulus(A_KEY, '0, 1'b0, 1'b1);
    repeat (40) tick();
    checkOutput("key0 held", bus.rdata, 32'h11);
    applyStimulus(A_KEY, 32'h10, 1'b1, 1'b0);
    tick();
    applyStimulus(A_KEY, '0, 1'b0, 1'b1);
    #1;
    checkOutput("key0 after w1c", bus.rdata, 32'h01);
    KEY = 4'hF;
    idle(40);
    applyStimulus(A_KEY, 32'hF0, 1'b1, 1'b0);
    tick();
    applyStimulus(A_KEY, '0, 1'b0, 1'b1);
    #1;
    checkOutput("key idle", bus.rdata, 32'h0);

`ifdef IO_DEBOUNCE_EN
    KEY = 4'b1101;
    repeat (5) tick();
    KEY = 4'hF;
    repeat (40) tick();
    checkOutput("key1 glitch", bus.rdata, 32'h0);
`else
    KEY = 4'b1101;
    tick();
    tick();
    checkOutput("key1 edge+2", bus.rdata, 32'h02);
    tick();
    checkOutput("key1 edge+3", bus.rdata, 32'h22);
    KEY = 4'hF;
    idle(40);
    applyStimulus(A_KEY, 32'hF0, 1'b1, 1'b0);
    tick();
`endif

    // W1C lands on the same edge that sets press[0].
    KEY = 4'b1110;
    idle(2 + FILT_LAT);
    applyStimulus(A_KEY, 32'h10, 1'b1, 1'b0);
    tick();
    applyStimulus(A_KEY, '0, 1'b0, 1'b1);
    #1;
    checkOutput("set beats clear", bus.rdata, 32'h11);

    addrs = '{A_HEX, A_LEDR, A_LEDG, A_KEY, A_SW, 32'hF0000020, 32'hF00000FC, 32'h10000004};
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (hold == 0) begin
        KEY = 4'($urandom);
        SW = 10'($urandom);
        hold = $urandom_range(1, 25);
      end
      hold--;
      applyStimulus(addrs[$urandom_range(0, 7)], $urandom, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      #1;
      checkOutput("rand rdata", bus.rdata, expRead(bus.addr, bus.re));
      checkOutput("rand io_hit", bus.io_hit, {31'b0, bus.addr[31:8] == 24'hF00000});
      tick();
      checkRegs("rand");
    end

    // Asynchronous reset in the middle of a cycle, with a store pending.
    KEY = 4'hF;
    applyStimulus(A_LEDR, 32'h3FF, 1'b1, 1'b0);
    tick();
    checkOutput("LEDR all on", LEDR, 32'h3FF);
    applyStimulus(A_HEX, 32'hBEEF, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset LEDR", LEDR, 32'h0);
    checkOutput("async reset HEX", HEX, 32'h0);
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    checkRegs("post reset");
    checkOutput("post reset HEX", HEX, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 Parameter DBITS, default 32, data and address width.
REQ-002 Parameter ADDR_HEX, default 32'hF0000000, HEX display register address.
REQ-003 Parameter ADDR_LEDR, default 32'hF0000004, red LED register address.
REQ-004 Parameter ADDR_LEDG, default 32'hF0000008, green LED register address.
REQ-005 Parameter ADDR_KEY, default 32'hF0000010, key status register address.
REQ-006 Parameter ADDR_SW, default 32'hF0000014, switch register address.
REQ-007 Parameter DEBOUNCE_CYCLES, default 16, stable-input cycle count.
REQ-008 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-009 Port reset_n, input, 1, reset, asynchronous and active-low.
REQ-010 Port addr, input, DBITS, ALU result used as the effective address.
REQ-011 Port wdata, input, DBITS, store data.
REQ-012 Port we, input, 1, store strobe, valid for one cycle per store.
REQ-013 Port re, input, 1, load strobe.
REQ-014 Port io_hit, output, 1, addr[31:8] == 24'hF00000; the datapath uses it to select io_ctrl over data memory.
REQ-015 Port rdata, output, DBITS, load data.
REQ-016 Port KEY, input, 4, raw pushbuttons, active-low (0 = pressed).
REQ-017 Port SW, input, 10, raw slide switches.
REQ-018 Ports HEX (16), LEDR (10) and LEDG (8), outputs; each is driven directly from its register.

Function
REQ-019 A write takes effect at the rising edge where we=1 and io_hit=1; it updates the register that addr selects.
REQ-020 A write to ADDR_HEX, ADDR_LEDR or ADDR_LEDG loads wdata[15:0], wdata[9:0] or wdata[7:0] respectively.
REQ-021 Reads are combinational: when re=1 and io_hit=1, rdata is valid in the same cycle; otherwise rdata is 0.
REQ-022 Read-back of HEX, LEDR and LEDG returns the register value, zero-extended.
REQ-023 Each KEY and SW bit passes through a 2-flop synchronizer before any use.
REQ-024 The ADDR_SW read returns the filtered SW value in [9:0]; the upper bits are 0.
REQ-025 The ADDR_KEY read returns {24'b0, press[3:0], ~key_f[3:0]}, where key_f is the filtered KEY value; bits [3:0] read 1 while a key is held.
REQ-026 press[i] is a sticky flag; it is set on the cycle key_f[i] goes from 1 to 0.
REQ-027 A write to ADDR_KEY clears each press[i] whose wdata[4+i] is 1 (write-1-to-clear).
REQ-028 If a set and a clear hit press[i] in the same cycle, the set wins.
REQ-029 Writes to ADDR_SW are ignored.
REQ-030 Any io_hit address that is not mapped reads 0; writes to it are ignored.
REQ-031 When io_hit=0, the block performs no write and keeps rdata at 0.
REQ-032 If we and re are both 1, the read returns the value from before the write; the new value is visible from the next cycle.

Reset
REQ-033 While reset_n=0: HEX, LEDR, LEDG and press are 0.
REQ-034 While reset_n=0: the KEY synchronizer and key_f are 4'hF (released); the SW synchronizer and filter are 0; debounce counters are 0.
REQ-035 If reset is asserted mid-write, the write is lost.
REQ-036 The first edge after reset_n rises behaves as a normal cycle; no spurious press is set.

Configuration
REQ-037 With IO_DEBOUNCE_EN defined, each KEY and SW bit has a counter.
REQ-038 In that case the counter clears whenever the synchronized bit equals the filtered bit.
REQ-039 In that case the filtered bit takes the synchronized value once the counter reaches DEBOUNCE_CYCLES-1 while they differ, and the counter then clears.
REQ-040 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the filtered value.
REQ-041 With IO_DEBOUNCE_EN undefined, the filtered value equals the synchronizer output; input-to-read latency is 2 cycles and no counters exist.

Verification
REQ-042 Store 32'h00001234 to ADDR_HEX -> HEX=16'h1234 next cycle; a load returns 32'h00001234.
REQ-043 Store 32'hFFFFFFFF to ADDR_LEDG -> LEDG=8'hFF; a load returns 32'h000000FF; a store to ADDR_SW leaves the SW read unchanged.
REQ-044 Drive KEY=4'b1110 for 40 cycles -> ADDR_KEY read = 32'h11; write 32'h10 -> reads 32'h01 while held.
REQ-045 Define IO_DEBOUNCE_EN and pulse KEY[1] low for 5 cycles -> ADDR_KEY read stays 0. Undefined -> press[1] sets 3 cycles after the falling edge.
REQ-046 Place a press edge in the same cycle as a W1C of that bit -> the bit reads 1. Store to 32'hF0000020 -> all registers unchanged and a load returns 0.
REQ-047 Assert reset_n=0 asynchronously mid-cycle with LEDR=10'h3FF -> LEDR=0 immediately, with no clock edge.
